// File: rtl/sram_access_sequencer.sv
// SRAM access sequencer: buffers write-through stores in a FIFO, drains them ahead of
// read-miss fills over a single-ported SRAM handshake, and raises stall_cpu.
module sram_access_sequencer #(
  parameter int WB_DEPTH    = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_req,
  input  logic                          wr_req,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_done,
  output logic                          stall_cpu,
  output logic                          sram_rd,
  output logic                          sram_wr,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [DATA_W-1:0]             sram_wdata,
  input  logic [DATA_W-1:0]             sram_rdata,
  input  logic                          sram_ready,
  output logic [$clog2(WB_DEPTH+1)-1:0] wb_count,
  output logic                          timeout_err,
  output logic                          proto_err
);

  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH+1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC+1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_ISSUE = 2'd1,
    ST_RD_ISSUE = 2'd2,
    ST_RD_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wb_addr [WB_DEPTH];
  logic [DATA_W-1:0]   r_wb_data [WB_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_sram_rd;
  logic                r_sram_wr;
  logic [ADDR_W-1:0]   r_sram_addr;
  logic [DATA_W-1:0]   r_sram_wdata;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_done;
  logic                r_timeout_err;
  logic                r_proto_err;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_strobe;

  assign w_full   = (r_count == CNT_W'(WB_DEPTH));
  assign w_empty  = (r_count == '0);
  // A read in the same cycle wins; the colliding write is dropped and flagged.
  assign w_push   = wr_req & ~rd_req & ~w_full;
  assign w_pop    = (r_state == ST_WR_ISSUE) & sram_ready;
  assign w_strobe = r_sram_rd | r_sram_wr;

  assign stall_cpu   = (rd_req & ~r_rd_done) | (wr_req & w_full);
  assign rd_data     = r_rd_data;
  assign rd_done     = r_rd_done;
  assign sram_rd     = r_sram_rd;
  assign sram_wr     = r_sram_wr;
  assign sram_addr   = r_sram_addr;
  assign sram_wdata  = r_sram_wdata;
  assign wb_count    = r_count;
  assign timeout_err = r_timeout_err;
  assign proto_err   = r_proto_err;

  // Write-buffer storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_wr_ptr] <= addr;
      r_wb_data[r_wr_ptr] <= wdata;
    end
  end

  // Write-buffer pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer FSM with registered SRAM strobes and read return
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sram_rd    <= 1'b0;
      r_sram_wr    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_rd_data    <= '0;
      r_rd_done    <= 1'b0;
    end else begin
      r_rd_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state      <= ST_WR_ISSUE;
            r_sram_wr    <= 1'b1;
            r_sram_addr  <= r_wb_addr[r_rd_ptr];
            r_sram_wdata <= r_wb_data[r_rd_ptr];
          end else if (rd_req) begin
            r_state     <= ST_RD_ISSUE;
            r_sram_rd   <= 1'b1;
            r_sram_addr <= addr;
          end
        end
        ST_WR_ISSUE: begin
          if (sram_ready) begin
            r_sram_wr <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_RD_ISSUE: begin
          if (sram_ready) begin
            r_sram_rd <= 1'b0;
            r_rd_data <= sram_rdata;
            r_rd_done <= 1'b1;
            r_state   <= ST_RD_DONE;
          end
        end
        ST_RD_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Wait watchdog and sticky protocol flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      if (w_strobe && sram_ready) begin
        r_to_cnt <= '0;
      end else if (w_strobe) begin
        if (r_to_cnt != TO_W'(TIMEOUT_CYC)) r_to_cnt <= r_to_cnt + TO_W'(1);
        if (r_to_cnt >= TO_W'(TIMEOUT_CYC - 1)) r_timeout_err <= 1'b1;
      end
      if (rd_req && wr_req) r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Scoreboard bench: stimulus pushes expected SRAM ops and read returns; a negedge
// monitor pops them as the DUT completes handshakes and raises rd_done.
module tb_sram_access_sequencer;

  localparam int WB  = 4;
  localparam int TO  = 255;

  typedef struct packed {
    logic        wr;
    logic [16:0] a;
    logic [31:0] d;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, wr_req;
  logic [16:0] addr;
  logic [31:0] wdata;
  logic [31:0] rd_data;
  logic        rd_done, stall_cpu, sram_rd, sram_wr;
  logic [16:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ready;
  logic [2:0]  wb_count;
  logic        timeout_err, proto_err;

  sram_access_sequencer #(.WB_DEPTH(WB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .wdata(wdata), .rd_data(rd_data), .rd_done(rd_done), .stall_cpu(stall_cpu),
    .sram_rd(sram_rd), .sram_wr(sram_wr), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .wb_count(wb_count), .timeout_err(timeout_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;
  int          rmode  = 0;
  int          cyc    = 0;
  int          n_push = 0;
  int          n_pop  = 0;
  int          wait_cnt = 0;
  bit          to_model = 0;
  bit          proto_model = 0;
  op_t         exp_ops[$];
  logic [31:0] exp_rd[$];
  logic [31:0] ref_mem [int];
  logic [31:0] phys_mem [int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [16:0] a);
    return {a[14:0], a} ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] phys_rd(input logic [16:0] a);
    if (phys_mem.exists(int'(a))) return phys_mem[int'(a)];
    return init_val(a);
  endfunction

  // Program-order value of a word: newest pending write, else committed contents.
  function automatic logic [31:0] expect_val(input logic [16:0] a);
    for (int i = exp_ops.size() - 1; i >= 0; i--)
      if (exp_ops[i].wr && exp_ops[i].a == a) return exp_ops[i].d;
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  // SRAM responder
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    case (rmode)
      0:       sram_ready = 1'b1;
      1:       sram_ready = 1'b0;
      2:       sram_ready = 1'($urandom_range(0, 1));
      default: sram_ready = (cyc % 3 == 0);
    endcase
    sram_rdata = phys_rd(sram_addr);
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      op_t op;
      chk("one_strobe", {31'd0, sram_rd & sram_wr}, 32'd0);
      chk("wb_count", {29'd0, wb_count}, n_push - n_pop);
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, to_model});
      chk("proto_err", {31'd0, proto_err}, {31'd0, proto_model});
      if (rd_done) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_done_unexpected act=1 exp=0 t=%0t", $time);
        end else begin
          chk("rd_data", rd_data, exp_rd.pop_front());
        end
      end
      if ((sram_rd || sram_wr) && sram_ready) begin
        wait_cnt = 0;
        if (exp_ops.size() == 0) begin
          checks++; errors++;
          $display("FAIL sram_op_unexpected act_wr=%0d addr=%h exp=none", sram_wr, sram_addr);
        end else begin
          op = exp_ops.pop_front();
          chk("op_kind", {31'd0, sram_wr}, {31'd0, op.wr});
          chk("op_addr", {15'd0, sram_addr}, {15'd0, op.a});
          if (op.wr) begin
            chk("op_wdata", sram_wdata, op.d);
            ref_mem[int'(op.a)] = op.d;
          end
        end
        if (sram_wr) begin
          phys_mem[int'(sram_addr)] = sram_wdata;
          n_pop++;
        end
      end else if (sram_rd || sram_wr) begin
        wait_cnt++;
        if (wait_cnt >= TO) to_model = 1'b1;
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic do_write(input logic [16:0] a, input logic [31:0] d, input int max_cyc,
                          output bit acc);
    int occ;
    int n;
    n = 0; acc = 0;
    wr_req = 1'b1; addr = a; wdata = d;
    while (!acc && n < max_cyc) begin
      occ = n_push - n_pop;
      @(negedge clk);
      chk("stall_wr", {31'd0, stall_cpu}, (occ == WB) ? 32'd1 : 32'd0);
      @(posedge clk);
      if (occ < WB) begin
        acc = 1;
        n_push++;
        exp_ops.push_back('{wr: 1'b1, a: a, d: d});
      end
      n++;
      #1;
    end
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [16:0] a, input bit with_wr, output int stalls,
                         output int first_rd);
    int n;
    bit done;
    exp_rd.push_back(expect_val(a));
    exp_ops.push_back('{wr: 1'b0, a: a, d: 32'd0});
    rd_req = 1'b1; addr = a;
    if (with_wr) begin wr_req = 1'b1; wdata = $urandom; end
    stalls = 0; first_rd = -1; n = 0; done = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      if (sram_rd && first_rd < 0) first_rd = n;
      if (rd_done) begin
        chk("stall_rd_done", {31'd0, stall_cpu}, 32'd0);
        done = 1;
      end else begin
        chk("stall_rd", {31'd0, stall_cpu}, 32'd1);
        stalls++;
      end
      @(posedge clk);
      if (n == 0 && with_wr) proto_model = 1'b1;
      n++;
      #1;
      wr_req = 1'b0;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL read_timeout act=no_rd_done exp=rd_done addr=%h", a);
    end
    rd_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n_push != n_pop && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n_push != n_pop) begin
      checks++; errors++;
      $display("FAIL drain_timeout act=%0d exp=0", n_push - n_pop);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    exp_ops.delete();
    exp_rd.delete();
    n_push = 0; n_pop = 0; wait_cnt = 0;
    to_model = 1'b0; proto_model = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          st, fr;
    logic [16:0] pool [8];
    logic [16:0] wrap_a [10];

    rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wdata = '0;
    sram_ready = 1'b0; sram_rdata = '0;
    repeat (2) @(posedge clk);
    mon_en = 1;
    @(negedge clk);
    chk("rst_rd_done", {31'd0, rd_done}, 32'd0);
    chk("rst_sram_rd", {31'd0, sram_rd}, 32'd0);
    chk("rst_sram_wr", {31'd0, sram_wr}, 32'd0);
    chk("rst_sram_addr", {15'd0, sram_addr}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_stall", {31'd0, stall_cpu}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Read with empty buffer and immediate ready
    rmode = 0;
    phys_mem[17'h00A5] = 32'hDEADBEEF;
    ref_mem[17'h00A5]  = 32'hDEADBEEF;
    @(posedge clk); #1;
    do_read(17'h00A5, 0, st, fr);
    chk("lat_stall_cycles", st, 2);
    chk("lat_first_rd", fr, 1);

    // Fill buffer with SRAM stalled
    rmode = 1;
    for (int i = 0; i < 4; i++) do_write(17'(16'h0100 + i), $urandom, 1, acc);
    chk("fill_count", {29'd0, wb_count}, 32'd4);
    do_write(17'h0104, 32'hCAFE0005, 2, acc);
    wr_req = 1'b1; addr = 17'h0104; wdata = 32'hCAFE0005;
    @(negedge clk);
    chk("fill_stall5", {31'd0, stall_cpu}, 32'd1);
    @(posedge clk); #1;
    wr_req = 1'b0;
    rmode = 0;
    do_write(17'h0104, 32'hCAFE0005, 50, acc);
    drain();

    // Read-after-write ordering
    do_write(17'h1FFFF, 32'h12345678, 10, acc);
    do_read(17'h1FFFF, 0, st, fr);
    chk("raw_first_rd", fr, 3);
    chk("raw_stalls", st, 4);

    // Pointer wrap with ready every third cycle
    rmode = 3;
    for (int i = 0; i < 10; i++) begin
      wrap_a[i] = 17'($urandom);
      do_write(wrap_a[i], $urandom, 200, acc);
    end
    drain();
    rmode = 0;
    do_read(wrap_a[9], 0, st, fr);
    do_read(wrap_a[0], 0, st, fr);

    // Randomized mix
    rmode = 2;
    for (int i = 0; i < 8; i++) pool[i] = 17'($urandom);
    pool[0] = 17'h00000; pool[1] = 17'h1FFFF;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) do_read(pool[$urandom_range(0, 7)], 0, st, fr);
      else do_write(pool[$urandom_range(0, 7)], $urandom, 200, acc);
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
    end
    drain();

    // Simultaneous read and write request
    rmode = 0;
    do_read(pool[2], 1, st, fr);
    chk("proto_set", {31'd0, proto_err}, 32'd1);
    chk("proto_no_push", {29'd0, wb_count}, 32'd0);

    // Timeout on a stuck write
    rmode = 1;
    do_write(17'h0ABC, 32'h0BADF00D, 1, acc);
    repeat (200) @(posedge clk);
    #1;
    chk("timeout_early", {31'd0, timeout_err}, 32'd0);
    repeat (70) @(posedge clk);
    #1;
    chk("timeout_set", {31'd0, timeout_err}, 32'd1);
    rmode = 0;
    drain();
    chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset mid-drain
    rmode = 1;
    for (int i = 0; i < 3; i++) do_write(17'(17'h0200 + i), $urandom, 1, acc);
    @(posedge clk); #1;
    chk("mid_sram_wr", {31'd0, sram_wr}, 32'd1);
    do_reset();
    chk("rst2_wb_count", {29'd0, wb_count}, 32'd0);
    chk("rst2_sram_wr", {31'd0, sram_wr}, 32'd0);
    chk("rst2_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst2_proto", {31'd0, proto_err}, 32'd0);
    rmode = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst2_no_wr", {31'd0, sram_wr}, 32'd0);
    end
    @(posedge clk); #1;
    do_read(17'h0201, 0, st, fr);
    chk("post_rst_lat", st, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("ops_left", exp_ops.size(), 32'd0);
    chk("rd_left", exp_rd.size(), 32'd0);
    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
